// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // Default phase timing in clk cycles
    localparam int unsigned T_STROBE_DEF = 10;
    localparam int unsigned T_GAP_DEF    = 5;

    // Access direction, shared with the mode FSM
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // State encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_GAP = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_GAP = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_ADDR     = ST_ADDR,
        S_ADDR_GAP = ST_ADDR_GAP,
        S_DATA     = ST_DATA,
        S_DATA_GAP = ST_DATA_GAP,
        S_DONE     = ST_DONE
    } state_e;

    // Request fields captured when an access is accepted
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Pin-level bus drive
    typedef struct packed {
        logic              cs_n;
        logic              ad_n;
        logic              wr_n;
        logic              rd_n;
        logic              oe;
        logic [DATA_W-1:0] ad_out;
    } pins_t;

    localparam pins_t PINS_IDLE = '{
        cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, oe: 1'b0, ad_out: '0
    };

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request and pin-side signals of the RTC bus sequencer.
interface rtc_bus_sequencer_if
    import rtc_bus_pkg::*;
;
    logic              start;
    logic              RW;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] Rdata;
    logic              CS_n;
    logic              AD_n;
    logic              WR_n;
    logic              RD_n;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;

    // Mode FSM / pad side
    modport master (
        output start, RW, Addr, Wdata, ad_in,
        input  busy, done, Rdata, CS_n, AD_n, WR_n, RD_n, ad_out, ad_oe
    );

    // Sequencer side
    modport slave (
        input  start, RW, Addr, Wdata, ad_in,
        output busy, done, Rdata, CS_n, AD_n, WR_n, RD_n, ad_out, ad_oe
    );

endinterface

// File: rtl/rtc_phase_timer.sv
// Phase timer: up-counter with synchronous clear, flags the last cycle of a phase.
module rtc_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             expire_c
);

    logic [CNT_W-1:0] count_q;

    // Count cycles within the current phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expire_c = (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// One address-phase + data-phase access on the RTC multiplexed bus.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_STROBE = T_STROBE_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               Reset,
    rtc_bus_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    pins_t             pins_q, pins_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q;
    logic              timer_clr;
    logic [CNT_W-1:0]  limit;
    logic              expire_c;
    logic              capture_c;

    rtc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (Reset),
        .clear    (timer_clr),
        .limit    (limit),
        .expire_c (expire_c)
    );

    // State and latched request
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Next state, timer control, and next-cycle pin values decoded from the next state
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        timer_clr = 1'b0;
        limit     = CNT_W'(T_STROBE);
        pins_d    = PINS_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                timer_clr = 1'b1;
                if (bus.start) begin
                    state_d     = S_ADDR;
                    req_d.rw    = bus.RW;
                    req_d.addr  = bus.Addr;
                    req_d.wdata = bus.Wdata;
                end
            end
            S_ADDR: begin
                if (expire_c) begin
                    state_d   = S_ADDR_GAP;
                    timer_clr = 1'b1;
                end
            end
            S_ADDR_GAP: begin
                limit = CNT_W'(T_GAP);
                if (expire_c) begin
                    state_d   = S_DATA;
                    timer_clr = 1'b1;
                end
            end
            S_DATA: begin
                if (expire_c) begin
                    state_d   = S_DATA_GAP;
                    timer_clr = 1'b1;
                end
            end
            S_DATA_GAP: begin
                limit = CNT_W'(T_GAP);
                if (expire_c) begin
                    state_d   = S_DONE;
                    timer_clr = 1'b1;
                end
            end
            S_DONE: begin
                timer_clr = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                timer_clr = 1'b1;
                state_d   = S_IDLE;
            end
        endcase

        // Address is written even for reads and held through the gap
        unique case (state_d)
            S_ADDR: begin
                pins_d.cs_n   = 1'b0;
                pins_d.ad_n   = 1'b0;
                pins_d.wr_n   = 1'b0;
                pins_d.oe     = 1'b1;
                pins_d.ad_out = req_d.addr;
                busy_d        = 1'b1;
            end
            S_ADDR_GAP: begin
                pins_d.ad_n   = 1'b0;
                pins_d.oe     = 1'b1;
                pins_d.ad_out = req_d.addr;
                busy_d        = 1'b1;
            end
            S_DATA: begin
                pins_d.cs_n = 1'b0;
                busy_d      = 1'b1;
                if (req_d.rw == RW_WRITE) begin
                    pins_d.wr_n   = 1'b0;
                    pins_d.oe     = 1'b1;
                    pins_d.ad_out = req_d.wdata;
                end else begin
                    pins_d.rd_n = 1'b0;
                end
            end
            S_DATA_GAP: begin
                busy_d = 1'b1;
                if (req_d.rw == RW_WRITE) begin
                    pins_d.oe     = 1'b1;
                    pins_d.ad_out = req_d.wdata;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                pins_d = PINS_IDLE;
            end
        endcase
    end

    // Read data is sampled only at the edge closing the final DATA cycle
    assign capture_c = (state_q == S_DATA) && expire_c && (req_q.rw == RW_READ);

    // Registered pin drive and status
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pins_q  <= PINS_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            pins_q <= pins_d;
            busy_q <= busy_d;
            done_q <= done_d;
            if (capture_c) begin
                rdata_q <= bus.ad_in;
            end
        end
    end

    assign bus.CS_n   = pins_q.cs_n;
    assign bus.AD_n   = pins_q.ad_n;
    assign bus.WR_n   = pins_q.wr_n;
    assign bus.RD_n   = pins_q.rd_n;
    assign bus.ad_oe  = pins_q.oe;
    assign bus.ad_out = pins_q.ad_out;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Rdata  = rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer at T_STROBE=4, T_GAP=2.
module tb_rtc_bus_sequencer;
    import rtc_bus_pkg::*;

    localparam int TS   = 4;
    localparam int TG   = 2;
    localparam int DONE_J = 2*TS + 2*TG;   // cycle offset of the done pulse
    localparam int LAST = DONE_J + 1;      // first idle cycle after done

    typedef struct packed {
        logic       cs_n;
        logic       ad_n;
        logic       wr_n;
        logic       rd_n;
        logic       oe;
        logic [7:0] out;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] ad_early;
        logic [7:0] ad_last;
        logic [7:0] exp_rdata;
    } vec_t;

    localparam obs_t OBS_IDLE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] cur_rdata = 8'h00;
    logic prev_cs_n = 1'b1;
    logic prev_ad_n = 1'b1;
    vec_t tbl [6];
    vec_t v;

    rtc_bus_sequencer_if bus();

    rtc_bus_sequencer #(
        .T_STROBE (TS),
        .T_GAP    (TG),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic obs_t cur_obs();
        return {bus.CS_n, bus.AD_n, bus.WR_n, bus.RD_n, bus.ad_oe, bus.ad_out, bus.busy, bus.done};
    endfunction

    // Expected pins j cycles after the accepting edge, from the phase lengths
    function automatic obs_t exp_obs(int j, logic rw, logic [7:0] addr, logic [7:0] wdata);
        obs_t o;
        o = OBS_IDLE;
        if (j < TS) begin
            o.cs_n = 1'b0; o.ad_n = 1'b0; o.wr_n = 1'b0; o.oe = 1'b1; o.out = addr; o.busy = 1'b1;
        end else if (j < TS + TG) begin
            o.ad_n = 1'b0; o.oe = 1'b1; o.out = addr; o.busy = 1'b1;
        end else if (j < 2*TS + TG) begin
            o.cs_n = 1'b0; o.busy = 1'b1;
            if (rw) o.rd_n = 1'b0;
            else begin o.wr_n = 1'b0; o.oe = 1'b1; o.out = wdata; end
        end else if (j < DONE_J) begin
            o.busy = 1'b1;
            if (!rw) begin o.oe = 1'b1; o.out = wdata; end
        end else if (j == DONE_J) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input int j, input obs_t want);
        obs_t got;
        got = cur_obs();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s j=%0d got={cs,ad,wr,rd,oe,out,busy,done}=%h want=%h", name, j, got, want);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Protocol invariants on every sampled cycle out of reset
    task automatic mon_check();
        logic bad;
        bad = (!bus.WR_n && !bus.RD_n) || (bus.ad_oe && !bus.RD_n) ||
              ((bus.AD_n != prev_ad_n) && !prev_cs_n);
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL monitor t=%0t wr_n=%b rd_n=%b oe=%b ad_n=%b prev_ad_n=%b prev_cs_n=%b",
                     $time, bus.WR_n, bus.RD_n, bus.ad_oe, bus.AD_n, prev_ad_n, prev_cs_n);
        end
        prev_cs_n = bus.CS_n;
        prev_ad_n = bus.AD_n;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) mon_check();
    endtask

    task automatic drive_req(input vec_t r);
        bus.start = 1'b1;
        bus.RW    = r.rw;
        bus.Addr  = r.addr;
        bus.Wdata = r.wdata;
        bus.ad_in = r.ad_early;
    endtask

    // Full access; optionally pulse start with a different address during ADDR_GAP
    task automatic run_access(input vec_t r, input bit inject);
        tick();
        drive_req(r);
        for (int j = 0; j <= LAST; j++) begin
            tick();
            bus.start = 1'b0;
            if (inject && j == TS) begin
                bus.start = 1'b1;
                bus.Addr  = 8'h77;
            end
            check_obs("pins", j, exp_obs(j, r.rw, r.addr, r.wdata));
            check_byte("rdata", bus.Rdata, (j < 2*TS + TG) ? cur_rdata : r.exp_rdata);
            bus.ad_in = (j == 2*TS + TG - 1) ? r.ad_last : r.ad_early;
        end
        bus.start = 1'b0;
        cur_rdata = r.exp_rdata;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.RW    = 1'b0;
        bus.Addr  = 8'h00;
        bus.Wdata = 8'h00;
        bus.ad_in = 8'h00;

        //             rw    addr   wdata  early  last   rdata
        tbl[0] = '{1'b0, 8'h21, 8'h45, 8'h11, 8'h5A, 8'h00};
        tbl[1] = '{1'b1, 8'h33, 8'h00, 8'h11, 8'h5A, 8'h5A};
        tbl[2] = '{1'b0, 8'h99, 8'hC3, 8'h00, 8'hFF, 8'h5A};
        tbl[3] = '{1'b1, 8'h80, 8'hEE, 8'hA5, 8'h3C, 8'h3C};
        tbl[4] = '{1'b1, 8'h01, 8'h00, 8'h3C, 8'h81, 8'h81};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h81};

        // Reset state
        #12;
        check_obs("reset_pins", -1, OBS_IDLE);
        check_byte("reset_rdata", bus.Rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_access(tbl[i], 1'b0);

        // Start during ADDR_GAP is ignored and not queued
        v = '{1'b0, 8'h21, 8'h45, 8'h11, 8'h22, cur_rdata};
        run_access(v, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_obs("noqueue", i, OBS_IDLE);
        end

        // Start held high: next ADDR begins two cycles after done
        v = '{1'b0, 8'h5C, 8'hA7, 8'h00, 8'h00, cur_rdata};
        tick();
        drive_req(v);
        for (int j = 0; j <= LAST; j++) begin
            tick();
            check_obs("hold_first", j, exp_obs(j, v.rw, v.addr, v.wdata));
        end
        for (int j = 0; j <= LAST; j++) begin
            tick();
            bus.start = 1'b0;
            check_obs("hold_second", j, exp_obs(j, v.rw, v.addr, v.wdata));
        end

        // Reset asserted in the middle of a read DATA phase
        v = '{1'b1, 8'h3A, 8'h00, 8'h66, 8'h99, 8'h00};
        tick();
        drive_req(v);
        for (int j = 0; j <= TS + TG + 1; j++) begin
            tick();
            bus.start = 1'b0;
            check_obs("rst_pre", j, exp_obs(j, v.rw, v.addr, v.wdata));
        end
        #2 rst_n = 1'b0;
        #1;
        check_obs("rst_now", 0, OBS_IDLE);
        check_byte("rst_rdata", bus.Rdata, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2*LAST; i++) begin
            tick();
            check_obs("rst_after", i, OBS_IDLE);
        end
        n_cmp++;
        if (dut.state_q !== S_IDLE) begin
            n_err++;
            $display("FAIL rst_state got=%0d want=%0d", dut.state_q, S_IDLE);
        end
        check_byte("rst_after_rdata", bus.Rdata, 8'h00);
        cur_rdata = 8'h00;

        // Random accesses under the protocol monitor
        for (int i = 0; i < 8; i++) begin
            v.rw        = 1'($urandom_range(0, 1));
            v.addr      = 8'($urandom);
            v.wdata     = 8'($urandom);
            v.ad_early  = 8'($urandom);
            v.ad_last   = 8'($urandom);
            v.exp_rdata = v.rw ? v.ad_last : cur_rdata;
            run_access(v, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Executes one access on the RTC chip's multiplexed address/data bus: an address phase followed by a data phase, with chip-select and strobe timing set by parameters.
It is the bus-side counterpart of the general mode state machine. That machine decides read vs write (RW=1 read, RW=0 write) and the register to touch. This block turns each request into the pin-level sequence and returns read data.
It sits between the mode FSM and the RTC pins. Pin tri-stating is done one level up from ad_out/ad_oe.

Parameters:
T_STROBE, 10, clk cycles a strobe (WR_n or RD_n) is held low in each phase; must be >=1
T_GAP, 5, clk cycles of CS_n-high recovery after each strobe; must be >=1
CNT_W, 8, timer width; must hold max(T_STROBE,T_GAP)-1

Ports:
clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
start  in  1  request pulse/level; sampled only in IDLE
RW  in  1  1=read, 0=write; latched with start
Addr  in  8  RTC register address; latched with start
Wdata  in  8  write data; latched with start
busy  out  1  high from the first ADDR cycle through the last DATA_GAP cycle
done  out  1  one-cycle pulse when the access completes
Rdata  out  8  last read value; holds until the next read completes
CS_n  out  1  RTC chip select, active low
AD_n  out  1  bus phase: 0=address, 1=data
WR_n  out  1  write strobe, active low
RD_n  out  1  read strobe, active low
ad_out  out  8  bus drive value
ad_oe  out  1  1 = drive ad_out onto the pins
ad_in  in  8  bus value from the pins

Behaviour:
- All outputs are registers.
- Reset (async, Reset=0): state IDLE, timer 0, CS_n=1, AD_n=1, WR_n=1, RD_n=1, ad_oe=0, ad_out=0, busy=0, done=0, Rdata=0, latched fields 0.
- Reset mid-access aborts at once. No partial strobe survives. No done pulse. Rdata keeps its reset value 0.
- FSM states: IDLE, ADDR, ADDR_GAP, DATA, DATA_GAP, DONE.
- IDLE:
  - All strobes high, CS_n=1, ad_oe=0.
  - start=1 at edge k latches RW/Addr/Wdata. From edge k: state=ADDR, busy=1.
- ADDR, T_STROBE cycles: CS_n=0, AD_n=0, WR_n=0, ad_oe=1, ad_out=Addr. The address is always written, even for reads.
- ADDR_GAP, T_GAP cycles: CS_n=1, WR_n=1, AD_n=0. ad_oe=1 and ad_out=Addr are held (address hold).
- DATA, T_STROBE cycles: CS_n=0, AD_n=1.
  - Write: WR_n=0, ad_oe=1, ad_out=Wdata.
  - Read: RD_n=0, ad_oe=0.
  - On a read, Rdata captures ad_in only at the edge ending the last DATA cycle (timer==T_STROBE-1). Earlier ad_in values are ignored.
- DATA_GAP, T_GAP cycles: CS_n=1, strobes high, AD_n=1.
  - Write: ad_oe=1, Wdata held.
  - Read: ad_oe=0.
- DONE, 1 cycle: done=1, busy=0, CS_n=1, strobes high, ad_oe=0, AD_n=1. Always goes to IDLE next.
- Timing and latency:
  - done is high in the cycle after edge k+2*T_STROBE+2*T_GAP.
  - The minimum request-to-request spacing is 2*T_STROBE+2*T_GAP+2 cycles.
- Timer: counts up from 0 on state entry. The state advances when timer==limit-1 (limit is T_STROBE or T_GAP), and the timer clears on advance.
- start while busy or in DONE is ignored and not queued. A start held high is accepted on the next IDLE cycle.
- WR_n and RD_n are never low in the same cycle. CS_n=1 on every cycle where AD_n toggles.
- ad_oe=0 whenever RD_n=0.
- A write never modifies Rdata.

Decomposition:
- Package rtc_bus_pkg holds:
  - the state encoding localparams (3-bit)
  - RW_READ=1'b1 and RW_WRITE=1'b0, shared with the mode FSM
  - the default T_STROBE/T_GAP values
- Sub-module rtc_phase_timer: CNT_W-bit up-counter with clear and an expire flag (count==limit-1), limit as an input.

Test Plan:
- Write, T_STROBE=4, T_GAP=2, start at edge k with RW=0, Addr=0x21, Wdata=0x45 -> ADDR cycles k..k+3 with CS_n=0, AD_n=0, WR_n=0, ad_out=0x21. DATA cycles k+6..k+9 with WR_n=0, ad_out=0x45, ad_oe=1. done a single cycle after edge k+12. Rdata unchanged.
- Read, same params, Addr=0x33. ad_in=0x11 until the last DATA cycle, then 0x5A -> RD_n low 4 cycles, ad_oe=0 throughout DATA, Rdata=0x5A after done, WR_n stays 1 in DATA.
- start pulsed again during ADDR_GAP with Addr=0x77 -> ignored; no second access; busy drops at DONE.
- start held high continuously -> second ADDR begins exactly 2 cycles after the first done cycle. Spacing is 14 cycles at T_STROBE=4, T_GAP=2.
- Reset=0 asserted mid-DATA of a read -> same-time CS_n=1, RD_n=1, busy=0, no done. After release, state is IDLE and Rdata=0x00.
- Protocol monitor over random RW/Addr sequences -> never WR_n=0 and RD_n=0 together, never ad_oe=1 with RD_n=0, AD_n changes only while CS_n=1.
